// File: rtl/rs_alu.sv
// Reservation station for the integer ALU: holds issued ops until both
// operands resolve, then dispatches the lowest ready entry each cycle.
module rs_alu #(
  parameter int RS_SIZE    = 8,
  parameter int OP_WIDTH   = 7,
  parameter int VAL_WIDTH  = 32,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [OP_WIDTH-1:0]   issue_op,
  input  logic [ID_WIDTH-1:0]   issue_entry,
  input  logic [ADDR_WIDTH-1:0] issue_pc,
  input  logic [VAL_WIDTH-1:0]  issue_vj,
  input  logic [VAL_WIDTH-1:0]  issue_vk,
  input  logic [ID_WIDTH-1:0]   issue_qj,
  input  logic [ID_WIDTH-1:0]   issue_qk,
  input  logic                  issue_j_busy,
  input  logic                  issue_k_busy,
  input  logic                  alu_ready,
  input  logic [ID_WIDTH-1:0]   alu_entry,
  input  logic [VAL_WIDTH-1:0]  alu_val,
  input  logic                  lsb_ready,
  input  logic [ID_WIDTH-1:0]   lsb_entry,
  input  logic [VAL_WIDTH-1:0]  lsb_val,
  output logic                  rs_full,
  output logic                  execute,
  output logic [OP_WIDTH-1:0]   type_out,
  output logic [VAL_WIDTH-1:0]  val1,
  output logic [VAL_WIDTH-1:0]  val2,
  output logic [ID_WIDTH-1:0]   entry,
  output logic [ADDR_WIDTH-1:0] nowPC
);

  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic                  busy;
    logic [OP_WIDTH-1:0]   op;
    logic [VAL_WIDTH-1:0]  vj;
    logic [VAL_WIDTH-1:0]  vk;
    logic [ID_WIDTH-1:0]   qj;
    logic [ID_WIDTH-1:0]   qk;
    logic                  jb;
    logic                  kb;
    logic [ID_WIDTH-1:0]   tag;
    logic [ADDR_WIDTH-1:0] pc;
  } ent_t;

  ent_t [RS_SIZE-1:0] ent_q;
  ent_t [RS_SIZE-1:0] ent_d;

  logic                  exec_q, exec_d;
  logic [OP_WIDTH-1:0]   type_q, type_d;
  logic [VAL_WIDTH-1:0]  val1_q, val1_d;
  logic [VAL_WIDTH-1:0]  val2_q, val2_d;
  logic [ID_WIDTH-1:0]   tag_q, tag_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  logic [RS_SIZE-1:0] busy_v;
  logic               free_ok;
  logic [IW-1:0]      free_idx;
  logic               sel_ok;
  logic [IW-1:0]      sel_idx;

  // Returns {still_pending, value}; ALU broadcast wins over LSB.
  function automatic logic [VAL_WIDTH:0] opnd(
    input logic                 pend,
    input logic [ID_WIDTH-1:0]  q,
    input logic [VAL_WIDTH-1:0] v,
    input logic                 ar,
    input logic [ID_WIDTH-1:0]  ae,
    input logic [VAL_WIDTH-1:0] av,
    input logic                 lr,
    input logic [ID_WIDTH-1:0]  le,
    input logic [VAL_WIDTH-1:0] lv
  );
    logic [VAL_WIDTH:0] r;
    r = {pend, v};
    if (pend && ar && (q == ae)) begin
      r = {1'b0, av};
    end else if (pend && lr && (q == le)) begin
      r = {1'b0, lv};
    end
    return r;
  endfunction

  always_comb begin
    busy_v   = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    sel_ok   = 1'b0;
    sel_idx  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_v[i] = ent_q[i].busy;
      if (!ent_q[i].busy && !free_ok) begin
        free_ok  = 1'b1;
        free_idx = IW'(i);
      end
      if (ent_q[i].busy && !ent_q[i].jb &&
          !ent_q[i].kb && !sel_ok) begin
        sel_ok  = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  assign rs_full = &busy_v;

  always_comb begin
    ent_d  = ent_q;
    exec_d = 1'b0;
    type_d = type_q;
    val1_d = val1_q;
    val2_d = val2_q;
    tag_d  = tag_q;
    pc_d   = pc_q;
    if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_d[i].busy = 1'b0;
      end
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent_q[i].busy) begin
          {ent_d[i].jb, ent_d[i].vj} = opnd(
            ent_q[i].jb, ent_q[i].qj, ent_q[i].vj,
            alu_ready, alu_entry, alu_val,
            lsb_ready, lsb_entry, lsb_val);
          {ent_d[i].kb, ent_d[i].vk} = opnd(
            ent_q[i].kb, ent_q[i].qk, ent_q[i].vk,
            alu_ready, alu_entry, alu_val,
            lsb_ready, lsb_entry, lsb_val);
        end
      end
      if (sel_ok) begin
        exec_d = 1'b1;
        type_d = ent_q[sel_idx].op;
        val1_d = ent_q[sel_idx].vj;
        val2_d = ent_q[sel_idx].vk;
        tag_d  = ent_q[sel_idx].tag;
        pc_d   = ent_q[sel_idx].pc;
        ent_d[sel_idx].busy = 1'b0;
      end
      // Issue targets a free slot, so it never collides with dispatch.
      if (issue_valid && !rs_full && free_ok) begin
        ent_d[free_idx].busy = 1'b1;
        ent_d[free_idx].op   = issue_op;
        ent_d[free_idx].qj   = issue_qj;
        ent_d[free_idx].qk   = issue_qk;
        ent_d[free_idx].tag  = issue_entry;
        ent_d[free_idx].pc   = issue_pc;
        {ent_d[free_idx].jb, ent_d[free_idx].vj} = opnd(
          issue_j_busy, issue_qj, issue_vj,
          alu_ready, alu_entry, alu_val,
          lsb_ready, lsb_entry, lsb_val);
        {ent_d[free_idx].kb, ent_d[free_idx].vk} = opnd(
          issue_k_busy, issue_qk, issue_vk,
          alu_ready, alu_entry, alu_val,
          lsb_ready, lsb_entry, lsb_val);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      ent_q  <= '0;
      exec_q <= 1'b0;
      type_q <= '0;
      val1_q <= '0;
      val2_q <= '0;
      tag_q  <= '0;
      pc_q   <= '0;
    end else if (rdy_in) begin
      ent_q  <= ent_d;
      exec_q <= exec_d;
      type_q <= type_d;
      val1_q <= val1_d;
      val2_q <= val2_d;
      tag_q  <= tag_d;
      pc_q   <= pc_d;
    end
  end

  assign execute  = exec_q;
  assign type_out = type_q;
  assign val1     = val1_q;
  assign val2     = val2_q;
  assign entry    = tag_q;
  assign nowPC    = pc_q;

endmodule
